// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_pkg
// Description : Shared definitions for the instruction fetch unit. Holds the
//               fetch FSM state encoding, the default reset PC and the layout
//               of a fetch-buffer entry {instruction, pc_plus4}.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    // Entry layout: [63:32] instruction word, [31:0] fetch address + 4.
    localparam int C_ENTRY_W   = 64;
    localparam int C_INSTR_LSB = 32;

    function automatic logic [C_ENTRY_W-1:0] pack_entry(
        input logic [31:0] instr,
        input logic [31:0] pc_plus4
    );
        return {instr, pc_plus4};
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Two-entry FIFO holding fetched {instruction, pc_plus4} entries
//               between the instruction memory and the IF/ID register.
//   Clk      in   clock, rising edge
//   Rst_n    in   asynchronous active-low reset
//   Push     in   write PushData at the tail (ignored when full)
//   PushData in   entry to write
//   Pop      in   drop the head entry (ignored when empty)
//   Flush    in   discard all entries; overrides Push/Pop
//   Count    out  number of valid entries (0..2)
//   Head     out  oldest entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = C_ENTRY_W
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Push,
    input  logic [WIDTH-1:0] PushData,
    input  logic             Pop,
    input  logic             Flush,
    output logic [1:0]       Count,
    output logic [WIDTH-1:0] Head
);

    localparam logic [1:0] C_FULL = 2'(DEPTH);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = Push && (r_count != C_FULL);
    assign w_pop_ok  = Pop  && (r_count != 2'd0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (Flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr] <= PushData;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        end
    end

    assign Count = r_count;
    assign Head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage. Issues one read at a time to the
//               instruction memory, buffers up to two responses and presents
//               the oldest one to the IF/ID register. Redirects flush the
//               buffer; a redirect that catches a read in flight waits in
//               DRAIN for the stale response before fetching again.
//   Clk            in   clock, rising edge
//   Rst_n          in   asynchronous active-low reset
//   IMemReq        out  read request, held until the response cycle
//   IMemAddr       out  word-aligned read address
//   IMemValid      in   response valid for the outstanding request
//   IMemData       in   response instruction word
//   Redirect       in   branch/jump redirect
//   RedirectPC     in   redirect target (low two bits ignored)
//   Stall          in   IF/ID holds its contents this cycle
//   FetchValid     out  InstructionOut/PCAdderOut are valid
//   InstructionOut out  fetched instruction
//   PCAdderOut     out  fetch address of that instruction + 4
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = C_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        Stall,
    output logic        FetchValid,
    output logic [31:0] InstructionOut,
    output logic [31:0] PCAdderOut
);

    localparam logic [1:0] C_DEPTH = 2'(BUF_DEPTH);

    fetch_state_e         r_state;
    fetch_state_e         w_state_next;
    logic [31:0]          r_pc;
    logic [31:0]          w_pc_next;
    logic                 r_req;
    logic                 w_req_next;
    // Set once the current request has been visible to memory for a full
    // cycle; a response is only legal from then on, so anything earlier
    // (e.g. a leftover from before reset) is ignored.
    logic                 r_issued;
    logic [1:0]           w_count;
    logic [1:0]           w_count_next;
    logic [C_ENTRY_W-1:0] w_head;
    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fetch_valid;
    logic [31:0]          w_redirect_pc;
    logic [31:0]          w_pc_plus4;
    logic                 w_unused_redirect_lsbs;

    assign w_redirect_pc          = {RedirectPC[31:2], 2'b00};
    assign w_unused_redirect_lsbs = ^RedirectPC[1:0];
    assign w_pc_plus4             = r_pc + 32'd4;

    assign w_fetch_valid = (w_count != 2'd0);
    assign w_accept      = (r_state == ST_FETCH) && r_req && r_issued && IMemValid;
    assign w_push        = w_accept && !Redirect;
    assign w_pop         = w_fetch_valid && !Stall;
    // Occupancy after this edge; decides whether a fresh request has room.
    assign w_count_next  = Redirect ? 2'd0
                                    : (w_count + {1'b0, w_push} - {1'b0, w_pop});

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (C_ENTRY_W)
    ) u_fetch_fifo (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Push     (w_push),
        .PushData (pack_entry(IMemData, w_pc_plus4)),
        .Pop      (w_pop),
        .Flush    (Redirect),
        .Count    (w_count),
        .Head     (w_head)
    );

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_req_next   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_FETCH;
                w_req_next   = 1'b1;
            end
            ST_FETCH: begin
                if (Redirect) begin
                    w_pc_next = w_redirect_pc;
                    if (r_req && !w_accept) begin
                        // Read still in flight: its response must be swallowed.
                        w_state_next = ST_DRAIN;
                    end else begin
                        // A response landing now is discarded; drop the
                        // request for one edge before fetching the target.
                        w_req_next = !r_req;
                    end
                end else if (r_req) begin
                    w_req_next = !w_accept;
                    if (w_accept) begin
                        w_pc_next = w_pc_plus4;
                    end
                end else begin
                    w_req_next = (w_count_next < C_DEPTH);
                end
            end
            ST_DRAIN: begin
                if (Redirect) begin
                    w_pc_next = w_redirect_pc;
                end
                if (IMemValid) begin
                    w_state_next = ST_FETCH;
                    w_req_next   = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= RESET_PC;
            r_req    <= 1'b0;
            r_issued <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_req    <= w_req_next;
            r_issued <= r_req && w_req_next;
        end
    end

    assign IMemReq        = r_req;
    assign IMemAddr       = r_pc;
    assign FetchValid     = w_fetch_valid;
    assign InstructionOut = w_fetch_valid ? w_head[C_ENTRY_W-1:C_INSTR_LSB] : 32'd0;
    assign PCAdderOut     = w_fetch_valid ? w_head[C_INSTR_LSB-1:0]         : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A memory model with
//               fixed or random latency answers requests; a program-order
//               model predicts the instruction stream, the buffer occupancy
//               and the next fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] C_TB_RESET_PC = 32'h0000_0000;

    logic        Clk;
    logic        Rst_n;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        Stall;
    logic        FetchValid;
    logic [31:0] InstructionOut;
    logic [31:0] PCAdderOut;

    instr_fetch_unit #(
        .RESET_PC  (C_TB_RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .IMemReq        (IMemReq),
        .IMemAddr       (IMemAddr),
        .IMemValid      (IMemValid),
        .IMemData       (IMemData),
        .Redirect       (Redirect),
        .RedirectPC     (RedirectPC),
        .Stall          (Stall),
        .FetchValid     (FetchValid),
        .InstructionOut (InstructionOut),
        .PCAdderOut     (PCAdderOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_pc;       // fetch address of the next entry to deliver
    logic [31:0] exp_fetch;    // address the next new request must use
    int          mcnt;         // entries fetched but not yet delivered
    bit          req_low_next;
    bit          mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt;
    int          lat_mode;     // 0 = random 1..3, else fixed latency
    bit          inject_late;
    bit          new_req_seen;
    int          n_deliv;
    logic        nxt_stall;
    logic        nxt_redir;
    logic [31:0] nxt_tgt;
    logic [31:0] q_req_addr[$];
    logic [31:0] q_pcp[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_F00D;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, expv);
        end
    endtask

    // One clock cycle: sample and check outputs, play memory, drive inputs,
    // then advance the reference model by the events of the coming edge.
    task automatic step();
        bit late;
        bit pop;
        bit acc;
        @(posedge Clk);
        #1;
        new_req_seen = 1'b0;
        check_eq("fetch_valid", 32'(FetchValid), 32'(mcnt != 0));
        if (FetchValid) begin
            check_eq("instr_out", InstructionOut, mem_word(exp_pc));
            check_eq("pc_adder_out", PCAdderOut, exp_pc + 32'd4);
            q_pcp.push_back(PCAdderOut);
        end
        if (req_low_next) check_eq("req_drop", 32'(IMemReq), 32'd0);

        IMemValid = 1'b0;
        IMemData  = 32'hDEAD_BEEF;
        if (mem_pend) begin
            if (IMemReq) check_eq("addr_stable", IMemAddr, mem_addr);
            mem_cnt--;
            if (mem_cnt == 0) begin
                IMemValid = 1'b1;
                IMemData  = mem_word(mem_addr);
                mem_pend  = 1'b0;
            end
        end else if (IMemReq) begin
            check_eq("req_addr", IMemAddr, exp_fetch);
            check_eq("req_room", 32'(mcnt < 2), 32'd1);
            mem_pend     = 1'b1;
            mem_addr     = IMemAddr;
            mem_cnt      = (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            new_req_seen = 1'b1;
            q_req_addr.push_back(IMemAddr);
        end
        late        = inject_late;
        inject_late = 1'b0;
        if (late) begin
            IMemValid = 1'b1;
            IMemData  = 32'hBAD0_BAD0;
        end

        Stall      = nxt_stall;
        Redirect   = nxt_redir;
        RedirectPC = nxt_tgt;
        nxt_redir  = 1'b0;

        pop = (mcnt != 0) && !Stall;
        acc = IMemValid && IMemReq && !late;
        req_low_next = acc;
        if (Redirect) begin
            mcnt      = 0;
            exp_pc    = {RedirectPC[31:2], 2'b00};
            exp_fetch = {RedirectPC[31:2], 2'b00};
        end else begin
            if (pop) begin
                exp_pc = exp_pc + 32'd4;
                n_deliv++;
            end
            if (acc) exp_fetch = exp_fetch + 32'd4;
            mcnt = mcnt + int'(acc) - int'(pop);
        end
    endtask

    // Called mid-cycle; asserts reset asynchronously and releases it mid-cycle
    // so the DUT spends one cycle in IDLE.
    task automatic do_reset();
        Rst_n      = 1'b0;
        IMemValid  = 1'b0;
        IMemData   = 32'd0;
        Redirect   = 1'b0;
        RedirectPC = 32'd0;
        Stall      = 1'b0;
        nxt_stall  = 1'b0;
        nxt_redir  = 1'b0;
        nxt_tgt    = 32'd0;
        #2;
        check_eq("rst_req", 32'(IMemReq), 32'd0);
        check_eq("rst_addr", IMemAddr, C_TB_RESET_PC);
        check_eq("rst_fetch_valid", 32'(FetchValid), 32'd0);
        check_eq("rst_instr", InstructionOut, 32'd0);
        check_eq("rst_pcp", PCAdderOut, 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n        = 1'b1;
        exp_pc       = C_TB_RESET_PC;
        exp_fetch    = C_TB_RESET_PC;
        mcnt         = 0;
        mem_pend     = 1'b0;
        mem_cnt      = 0;
        req_low_next = 1'b0;
        inject_late  = 1'b0;
        new_req_seen = 1'b0;
        q_req_addr.delete();
        q_pcp.delete();
    endtask

    initial begin
        logic [31:0] exp_addr_seq [3];
        logic [31:0] exp_pcp_seq [3];
        int          n_start;
        n_checks = 0;
        n_fail   = 0;
        n_deliv  = 0;
        lat_mode = 1;
        Rst_n    = 1'b1;
        #2;
        do_reset();

        // Straight-line fetch, 1-cycle memory, no stall.
        exp_addr_seq = '{32'h0, 32'h4, 32'h8};
        exp_pcp_seq  = '{32'h4, 32'h8, 32'hC};
        repeat (14) step();
        check_eq("seq_req_count", 32'(q_req_addr.size() >= 3), 32'd1);
        check_eq("seq_pcp_count", 32'(q_pcp.size() >= 3), 32'd1);
        if (q_req_addr.size() >= 3 && q_pcp.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check_eq("seq_req_addr", q_req_addr[i], exp_addr_seq[i]);
                check_eq("seq_pcp", q_pcp[i], exp_pcp_seq[i]);
            end
        end

        // Stall while the buffer fills, then release.
        #1;
        do_reset();
        nxt_stall = 1'b1;
        repeat (12) step();
        check_eq("stall_req_low", 32'(IMemReq), 32'd0);
        check_eq("stall_valid", 32'(FetchValid), 32'd1);
        check_eq("stall_pcp", PCAdderOut, 32'h4);
        step();
        check_eq("stall_hold_pcp", PCAdderOut, 32'h4);
        check_eq("stall_hold_instr", InstructionOut, mem_word(32'h0));
        nxt_stall = 1'b0;
        step();
        step();
        check_eq("unstall_second_valid", 32'(FetchValid), 32'd1);
        check_eq("unstall_second_pcp", PCAdderOut, 32'h8);
        repeat (4) step();

        // Redirect while the read of 0x8 is in flight, 3-cycle memory.
        #1;
        do_reset();
        lat_mode = 3;
        for (int k = 0; k < 60; k++) begin
            step();
            if (new_req_seen && IMemAddr == 32'h8) break;
        end
        check_eq("drain_req8_seen", IMemAddr, 32'h8);
        nxt_redir = 1'b1;
        nxt_tgt   = 32'h100;
        step();
        step();
        check_eq("drain_req_low", 32'(IMemReq), 32'd0);
        for (int k = 0; k < 20; k++) begin
            step();
            if (new_req_seen) break;
        end
        check_eq("drain_next_addr", IMemAddr, 32'h100);
        for (int k = 0; k < 20; k++) begin
            if (FetchValid) break;
            step();
        end
        check_eq("drain_first_pcp", PCAdderOut, 32'h104);

        // Redirect coinciding with the response.
        #1;
        do_reset();
        lat_mode = 1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (new_req_seen) break;
        end
        nxt_redir = 1'b1;
        nxt_tgt   = 32'h203;
        step();
        check_eq("redir_valid_dropped_resp", 32'(IMemValid), 32'd1);
        for (int k = 0; k < 20; k++) begin
            step();
            if (new_req_seen) break;
        end
        check_eq("redir_valid_next_addr", IMemAddr, 32'h200);
        for (int k = 0; k < 20; k++) begin
            if (FetchValid) break;
            step();
        end
        check_eq("redir_valid_pcp", PCAdderOut, 32'h204);

        // PC wrap at the top of the address space.
        lat_mode  = 2;
        nxt_redir = 1'b1;
        nxt_tgt   = 32'hFFFF_FFFC;
        step();
        for (int k = 0; k < 30; k++) begin
            step();
            if (FetchValid) break;
        end
        check_eq("wrap_pcp", PCAdderOut, 32'h0);
        for (int k = 0; k < 30; k++) begin
            step();
            if (new_req_seen && IMemAddr != 32'hFFFF_FFFC) break;
        end
        check_eq("wrap_next_addr", IMemAddr, 32'h0);

        // Reset in the middle of a request with a stale response after release.
        #1;
        do_reset();
        lat_mode = 3;
        for (int k = 0; k < 10; k++) begin
            step();
            if (new_req_seen) break;
        end
        step();
        #1;
        do_reset();
        inject_late = 1'b1;
        step();
        step();
        check_eq("late_resp_no_push", 32'(FetchValid), 32'd0);
        for (int k = 0; k < 20; k++) begin
            if (FetchValid) break;
            step();
        end
        check_eq("late_restart_pcp", PCAdderOut, C_TB_RESET_PC + 32'd4);
        check_eq("late_restart_instr", InstructionOut, mem_word(C_TB_RESET_PC));

        // Random traffic: latency, stalls and redirects.
        #1;
        do_reset();
        lat_mode = 0;
        n_start  = n_deliv;
        for (int c = 0; c < 3000; c++) begin
            nxt_stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                nxt_redir = 1'b1;
                case ($urandom_range(0, 2))
                    0:       nxt_tgt = $urandom();
                    1:       nxt_tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    default: nxt_tgt = 32'($urandom_range(0, 1023));
                endcase
            end
            step();
        end
        check_eq("random_progress", 32'((n_deliv - n_start) > 200), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
